// File: rtl/multiplier_pkg.sv
// Shared constants and sign-magnitude field helpers for the neuron multiplier.
// Default format is Q5.10: sign, 5 integer bits, 10 fraction bits.
package multiplier_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_INT_BITS  = 6;
  localparam int unsigned DEF_FRAC_BITS = 10;

  // Bit position of the sign in a sign-magnitude word of the given width.
  function automatic int unsigned sm_sign_idx(input int unsigned width);
    return width - 1;
  endfunction

  // Largest representable magnitude (all magnitude bits set).
  function automatic longint unsigned sm_mag_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/multiplier_mag_core.sv
// Combinational unsigned magnitude multiply, fixed-point rescale and
// saturation for the sign-magnitude multiplier.
module mult_mag_core
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic [WIDTH-2:0] ma,
  input  logic [WIDTH-2:0] mb,
  output logic [WIDTH-2:0] mag,
  output logic             ovf
);

  localparam int unsigned MW = WIDTH - 1;
  localparam int unsigned PW = 2 * MW;
  localparam logic [MW-1:0] MAG_MAX = MW'(sm_mag_max(WIDTH));

  logic [PW-1:0] p;
  logic [PW-1:0] q;

  // Right shift truncates toward zero; any surviving bit above the magnitude
  // field means the product does not fit and is clamped.
  always_comb begin
    p   = PW'(ma) * PW'(mb);
    q   = p >> FRAC_BITS;
    ovf = |q[PW-1:MW];
    mag = ovf ? MAG_MAX : q[MW-1:0];
  end

endmodule

// File: rtl/multiplier.sv
// Signed (sign-magnitude) fixed-point multiplier, weight x input, with a
// single registered stage, valid qualification and saturation on overflow.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned INT_BITS  = DEF_INT_BITS,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned SIGN = sm_sign_idx(WIDTH);

  generate
    if (WIDTH != INT_BITS + FRAC_BITS) begin : g_bad_format
      $error("multiplier: WIDTH must equal INT_BITS + FRAC_BITS");
    end
  endgenerate

  logic [WIDTH-2:0] mag;
  logic             ovf_c;
  logic             sign_c;
  logic [WIDTH-1:0] result_c;

  mult_mag_core #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_core (
    .ma  (a[WIDTH-2:0]),
    .mb  (b[WIDTH-2:0]),
    .mag (mag),
    .ovf (ovf_c)
  );

  // A zero magnitude always carries a positive sign, which also folds
  // negative-zero operands into plain zero.
  always_comb begin
    sign_c   = (a[SIGN] ^ b[SIGN]) & (|mag);
    result_c = {sign_c, mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= result_c;
        ovf    <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the sign-magnitude Q5.10 multiplier.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic [15:0] result;
  logic        ovf;

  multiplier #(.WIDTH(16), .INT_BITS(6), .FRAC_BITS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic        o;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        o;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  exp_t held;
  logic exp_v;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    longint unsigned p;
    longint unsigned q;
    exp_t e;
    p = {49'd0, x[14:0]} * {49'd0, y[14:0]};
    q = p / 1024;
    if (q >= 32768) begin
      e.o = 1'b1;
      e.r[14:0] = 15'h7fff;
    end else begin
      e.o = 1'b0;
      e.r[14:0] = q[14:0];
    end
    e.r[15] = (x[15] ^ y[15]) && (e.r[14:0] != 15'd0);
    return e;
  endfunction

  // Expected out_valid: in_valid one cycle late, dropped at once by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= in_valid;
  end

  always @(posedge clk) begin
    if (rst_n && in_valid) sb.push_back(cur_exp);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      held = '{16'h0000, 1'b0};
    end else begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: got out_valid=1 want no pending result");
        end else begin
          held = sb.pop_front();
          check("result", {16'd0, result}, {16'd0, held.r});
          check("ovf", {31'd0, ovf}, {31'd0, held.o});
        end
      end else begin
        check("result_hold", {16'd0, result}, {16'd0, held.r});
        check("ovf_hold", {31'd0, ovf}, {31'd0, held.o});
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] ta, input logic [15:0] tb_, input exp_t e);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb_;
    cur_exp  = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[$];
    logic [15:0] ra;
    logic [15:0] rb;

    vt.push_back('{16'h0066, 16'h000a, 16'h0000, 1'b0});
    vt.push_back('{16'h040a, 16'h0600, 16'h060F, 1'b0});
    vt.push_back('{16'h0866, 16'h8600, 16'h8C99, 1'b0});
    vt.push_back('{16'h840a, 16'h8600, 16'h060F, 1'b0});
    vt.push_back('{16'h7FFF, 16'h0800, 16'h7FFF, 1'b1});
    vt.push_back('{16'hFFFF, 16'h0800, 16'hFFFF, 1'b1});
    vt.push_back('{16'h8000, 16'h0400, 16'h0000, 1'b0});
    vt.push_back('{16'h0400, 16'h8000, 16'h0000, 1'b0});
    vt.push_back('{16'h0400, 16'h0400, 16'h0400, 1'b0});
    vt.push_back('{16'h8400, 16'h0400, 16'h8400, 1'b0});
    vt.push_back('{16'h7FFF, 16'h0400, 16'h7FFF, 1'b0});
    vt.push_back('{16'h4000, 16'h0800, 16'h7FFF, 1'b1});
    vt.push_back('{16'hC000, 16'h0800, 16'hFFFF, 1'b1});
    vt.push_back('{16'h8001, 16'h0001, 16'h0000, 1'b0});
    vt.push_back('{16'h0001, 16'h0400, 16'h0001, 1'b0});
    vt.push_back('{16'h8001, 16'h0400, 16'h8001, 1'b0});

    // Reset held low with in_valid asserted: outputs stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'h7FFF;
    b        = 16'h0800;
    cur_exp  = '{16'h7FFF, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;

    // Table vectors, back to back.
    foreach (vt[i]) drive(1'b1, vt[i].a, vt[i].b, '{vt[i].r, vt[i].o});
    drive(1'b0, 16'h0000, 16'h0000, '{16'h0000, 1'b0});

    // Random operands with random valid gaps.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rb[14:11] = '0;
      drive(1'($urandom_range(0, 1)), ra, rb, model(ra, rb));
    end
    drive(1'b0, 16'h0000, 16'h0000, '{16'h0000, 1'b0});

    // Valid pattern 1,1,0,1: result must hold across the gap.
    drive(1'b1, 16'h040a, 16'h0600, '{16'h060F, 1'b0});
    drive(1'b1, 16'h0866, 16'h8600, '{16'h8C99, 1'b0});
    drive(1'b0, 16'h0400, 16'h0400, '{16'h0400, 1'b0});
    drive(1'b1, 16'h7FFF, 16'h0800, '{16'h7FFF, 1'b1});
    drive(1'b0, 16'h0000, 16'h0000, '{16'h0000, 1'b0});
    drive(1'b0, 16'h0000, 16'h0000, '{16'h0000, 1'b0});

    // Reset just after a capture: the product is discarded immediately.
    drive(1'b1, 16'h040a, 16'h0600, '{16'h060F, 1'b0});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", {16'd0, result}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;

    // Recovery after reset.
    drive(1'b1, 16'h0400, 16'h0400, '{16'h0400, 1'b0});
    drive(1'b1, 16'h8600, 16'h0866, '{16'h8C99, 1'b0});
    repeat (3) drive(1'b0, 16'h0000, 16'h0000, '{16'h0000, 1'b0});

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
